// File: rtl/calc_core.sv
// Operand capture and arithmetic stage feeding the seven-segment display controller.
// Optional feature: define CALC_START_SYNC_EN to synchronize and edge-detect the start input.
module calc_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sw_a,
  input  logic [7:0]  sw_b,
  input  logic [1:0]  sw_op,
  input  logic        start,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [1:0]  op,
  output logic [15:0] result,
  output logic        neg,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] result_q, result_d;
  logic        neg_q, neg_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] acc_next;
  logic        start_qual;

`ifdef CALC_START_SYNC_EN
  // Two synchronizer stages plus one history flop; a single rising edge launches one operation.
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], start};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 3'b000;
    else        sync_q <= sync_d;
  end

  assign start_qual = sync_q[1] & ~sync_q[2];
`else
  assign start_qual = start;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    case (state_q)
      IDLE: begin
        if (start_qual) begin
          a_d   = sw_a;
          b_d   = sw_b;
          op_d  = sw_op;
          neg_d = 1'b0;
          if (sw_op == 2'd3) begin
            acc_d    = 16'd0;
            mcand_d  = {8'b0, sw_a};
            mplier_d = sw_b;
            cnt_d    = 3'd0;
            state_d  = MUL;
          end else begin
            state_d  = EXEC;
          end
        end
      end
      EXEC: begin
        case (op_q)
          2'd0: result_d = 16'd0;
          2'd1: result_d = {8'b0, a_q} + {8'b0, b_q};
          2'd2: begin
            if (a_q >= b_q) begin
              result_d = {8'b0, a_q - b_q};
              neg_d    = 1'b0;
            end else begin
              result_d = {8'b0, b_q - a_q};
              neg_d    = 1'b1;
            end
          end
          default: result_d = result_q;
        endcase
        state_d = DONE;
      end
      MUL: begin
        // Shift-add, one multiplier bit per cycle, LSB first.
        acc_d    = acc_next;
        mcand_d  = {mcand_q[14:0], 1'b0};
        mplier_d = {1'b0, mplier_q[7:1]};
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          result_d = acc_next;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      op_q     <= 2'd0;
      result_q <= 16'd0;
      neg_q    <= 1'b0;
      acc_q    <= 16'd0;
      mcand_q  <= 16'd0;
      mplier_q <= 8'd0;
      cnt_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign a      = a_q;
  assign b      = b_q;
  assign op     = op_q;
  assign result = result_q;
  assign neg    = neg_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_calc_core.sv
// Directed self-checking bench for calc_core; expected values are hand-computed.
// Follows CALC_START_SYNC_EN to choose the start-acceptance latency it expects.
module tb_calc_core;

`ifdef CALC_START_SYNC_EN
  localparam int LAT = 2;
  localparam int HOLD_DONES = 1;
`else
  localparam int LAT = 0;
  localparam int HOLD_DONES = 7;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  sw_a;
  logic [7:0]  sw_b;
  logic [1:0]  sw_op;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [1:0]  op;
  logic [15:0] result;
  logic        neg;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  calc_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_a   (sw_a),
    .sw_b   (sw_b),
    .sw_op  (sw_op),
    .start  (start),
    .a      (a),
    .b      (b),
    .op     (op),
    .result (result),
    .neg    (neg),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  // One-cycle start pulse across a single rising edge; returns at the following falling edge.
  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic [1:0] vop);
    @(negedge clk);
    sw_a  = va;
    sw_b  = vb;
    sw_op = vop;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic runAlu(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic [1:0] vop, input logic [15:0] exp_res, input logic exp_neg);
    applyStimulus(va, vb, vop);
    repeat (LAT) @(negedge clk);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
    checkOutput({tag, "_nodone"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
    checkOutput({tag, "_neg"}, {31'd0, neg}, {31'd0, exp_neg});
    checkOutput({tag, "_a"}, {24'd0, a}, {24'd0, va});
    checkOutput({tag, "_b"}, {24'd0, b}, {24'd0, vb});
    checkOutput({tag, "_op"}, {30'd0, op}, {30'd0, vop});
    @(negedge clk);
    checkOutput({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_idle_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic runMul(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic [15:0] prev_res, input logic [15:0] exp_res);
    applyStimulus(va, vb, 2'd3);
    repeat (LAT) @(negedge clk);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
    repeat (7) @(negedge clk);
    checkOutput({tag, "_hold_result"}, {16'd0, result}, {16'd0, prev_res});
    checkOutput({tag, "_nodone"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
    checkOutput({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    checkOutput({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int dcount;
    int first_busy;

    rst_n = 1'b0;
    sw_a  = 8'd0;
    sw_b  = 8'd0;
    sw_op = 2'd0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_result", {16'd0, result}, 32'd0);
    checkOutput("rst_a", {24'd0, a}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    runAlu("add", 8'd200, 8'd100, 2'd1, 16'd300, 1'b0);
    runAlu("add_max", 8'd255, 8'd255, 2'd1, 16'd510, 1'b0);
    runAlu("sub_neg", 8'd50, 8'd80, 2'd2, 16'd30, 1'b1);
    runAlu("sub_pos", 8'd80, 8'd50, 2'd2, 16'd30, 1'b0);
    runAlu("sub_eq", 8'd9, 8'd9, 2'd2, 16'd0, 1'b0);
    runMul("mul_max", 8'd255, 8'd255, 16'd0, 16'd65025);
    runAlu("pass", 8'd5, 8'd6, 2'd0, 16'd0, 1'b0);
    runMul("mul_13x11", 8'd13, 8'd11, 16'd0, 16'd143);
    runMul("mul_zero", 8'd0, 8'd17, 16'd143, 16'd0);

    // A second request during a multiply must be dropped, not queued.
    applyStimulus(8'd12, 8'd13, 2'd3);
    repeat (LAT + 2) @(negedge clk);
    sw_a  = 8'd1;
    sw_b  = 8'd2;
    sw_op = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rej_done", {31'd0, done}, 32'd1);
    checkOutput("rej_result", {16'd0, result}, 32'd156);
    checkOutput("rej_a", {24'd0, a}, 32'd12);
    checkOutput("rej_op", {30'd0, op}, 32'd3);
    dcount = 0;
    repeat (14) begin
      @(negedge clk);
      if (done) dcount++;
    end
    checkOutput("rej_no_second_done", dcount, 32'd0);

    // Reset in the middle of a multiply aborts with no done.
    applyStimulus(8'd200, 8'd3, 2'd3);
    repeat (LAT + 3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_result", {16'd0, result}, 32'd0);
    checkOutput("midrst_a", {24'd0, a}, 32'd0);
    checkOutput("midrst_b", {24'd0, b}, 32'd0);
    checkOutput("midrst_op", {30'd0, op}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_done", {31'd0, done}, 32'd0);
    dcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dcount++;
    end
    checkOutput("midrst_no_done", dcount, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    runAlu("post_rst_add", 8'd7, 8'd9, 2'd1, 16'd16, 1'b0);

    // Held start: level mode repeats every 3 cycles, synchronized mode fires once.
    @(negedge clk);
    sw_a  = 8'd3;
    sw_b  = 8'd4;
    sw_op = 2'd1;
    start = 1'b1;
    dcount = 0;
    first_busy = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dcount++;
      if (busy && first_busy < 0) first_busy = i;
    end
    start = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) dcount++;
    end
    checkOutput("hold_done_count", dcount, HOLD_DONES);
    checkOutput("hold_first_accept", first_busy, LAT);
    checkOutput("hold_result", {16'd0, result}, 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
